// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I main control: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// selects and strobes, and halts with sticky flags on illegal opcodes or memory timeouts.
module mc_ctrl #(
   parameter int TIMEOUT      = 255,
   parameter int TIMEOUT_W    = 8,
   parameter bit SUPPORT_JUMP = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic [2:0] state,
   output logic       mem_req,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic       alu_src_a,
   output logic       alu_src_b,
   output logic [1:0] aluop,
   output logic [1:0] wb_sel,
   output logic       reg_write,
   output logic       illegal,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TO_LAST_I[TIMEOUT_W-1:0];

   state_t               cur, nxt;
   logic [6:0]           op_q;
   logic [TIMEOUT_W-1:0] wait_q;
   logic                 illegal_q, fault_q;
   logic                 set_illegal, set_fault;
   logic                 timeout_hit;

   function automatic logic is_legal(input logic [6:0] op);
      logic jump_cls;
      jump_cls = (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
             (op == OP_BRANCH) || (SUPPORT_JUMP && jump_cls);
   endfunction

   assign state       = cur;
   assign illegal     = illegal_q;
   assign fault       = fault_q;
   assign timeout_hit = (TIMEOUT != 0) && !mem_ready && (wait_q == TO_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cur       <= S_IDLE;
         op_q      <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         cur       <= nxt;
         illegal_q <= illegal_q | set_illegal;
         fault_q   <= fault_q | set_fault;
         if (cur == S_DECODE) op_q <= opcode;
         // Counter measures only consecutive stall cycles within one wait state.
         if (nxt != cur) wait_q <= '0;
         else if (((cur == S_FETCH) || (cur == S_MEM)) && !mem_ready) wait_q <= wait_q + 1'b1;
      end
   end

   // mem_req holds from FETCH/MEM entry until the mem_ready cycle; mem_ready
   // completes a request only while mem_req is high and is ignored elsewhere.
   always_comb begin
      nxt         = cur;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_sel      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      aluop       = 2'b00;
      wb_sel      = 2'b00;
      reg_write   = 1'b0;
      set_illegal = 1'b0;
      set_fault   = 1'b0;
      case (cur)
         S_IDLE: nxt = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               nxt      = S_DECODE;
            end else if (timeout_hit) begin
               nxt       = S_HALT;
               set_fault = 1'b1;
            end
         end
         S_DECODE: begin
            if (is_legal(opcode)) nxt = S_EXEC;
            else begin
               nxt         = S_HALT;
               set_illegal = 1'b1;
            end
         end
         S_EXEC: begin
            nxt = S_WB;
            case (op_q)
               OP_R: aluop = 2'b10;
               OP_I: begin
                  aluop     = 2'b11;
                  alu_src_b = 1'b1;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_b = 1'b1;
                  nxt       = S_MEM;
               end
               OP_BRANCH: begin
                  aluop    = 2'b01;
                  pc_write = 1'b1;
                  pc_sel   = branch_taken ? 2'b01 : 2'b00;
                  nxt      = S_FETCH;
               end
               OP_AUIPC: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 1'b1;
               end
               OP_JALR: alu_src_b = 1'b1;
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_write = (op_q == OP_STORE);
            alu_src_b = 1'b1;
            if (mem_ready) begin
               if (op_q == OP_STORE) begin
                  pc_write = 1'b1;
                  nxt      = S_FETCH;
               end else nxt = S_WB;
            end else if (timeout_hit) begin
               nxt       = S_HALT;
               set_fault = 1'b1;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            nxt       = S_FETCH;
            case (op_q)
               OP_LOAD: wb_sel = 2'b01;
               OP_LUI:  wb_sel = 2'b11;
               OP_AUIPC: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 1'b1;
               end
               OP_JAL: begin
                  wb_sel = 2'b10;
                  pc_sel = 2'b01;
               end
               OP_JALR: begin
                  wb_sel    = 2'b10;
                  pc_sel    = 2'b10;
                  alu_src_b = 1'b1;
               end
               default: ;
            endcase
         end
         S_HALT:  nxt = S_HALT;
         default: nxt = S_IDLE;
      endcase
   end

endmodule
